// File: rtl/mux_out_filter.sv
// rtl/mux_out_filter.sv - synchronise, deglitch and edge-detect the raw mux output (optional MUX_FILT_GLITCH_CNT_EN)
module mux_out_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             z_in,
    input  logic             glitch_clr,
    output logic             filt_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int RUN_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_nxt;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;
    logic             filt_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             glitch;

    // Two-flop synchroniser; the FSM only ever looks at s2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= z_in;
            s2 <= s1;
        end
    end

    // State, run counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STABLE_LO;
            run        <= '0;
            filt_out   <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            run        <= run_nxt;
            filt_out   <= filt_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    // Next state: leave a stable level on the first differing sample, accept after a full run
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        case (state)
            STABLE_LO: begin
                if (s2) begin
                    state_nxt = PEND_HI;
                    run_nxt   = RUN_ONE;
                end
            end
            PEND_HI: begin
                if (!s2) begin
                    state_nxt = STABLE_LO;
                    run_nxt   = '0;
                end else if (run == RUN_LAST) begin
                    state_nxt = STABLE_HI;
                    run_nxt   = '0;
                end else begin
                    run_nxt = run + RUN_ONE;
                end
            end
            STABLE_HI: begin
                if (!s2) begin
                    state_nxt = PEND_LO;
                    run_nxt   = RUN_ONE;
                end
            end
            PEND_LO: begin
                if (s2) begin
                    state_nxt = STABLE_HI;
                    run_nxt   = '0;
                end else if (run == RUN_LAST) begin
                    state_nxt = STABLE_LO;
                    run_nxt   = '0;
                end else begin
                    run_nxt = run + RUN_ONE;
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                run_nxt   = '0;
            end
        endcase
    end

    // Outputs: level change with a one-cycle strobe on acceptance, glitch flag on an aborted pend
    always_comb begin
        filt_nxt = filt_out;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        glitch   = 1'b0;
        case (state)
            PEND_HI: begin
                if (!s2) begin
                    glitch = 1'b1;
                end else if (run == RUN_LAST) begin
                    filt_nxt = 1'b1;
                    rise_nxt = 1'b1;
                end
            end
            PEND_LO: begin
                if (s2) begin
                    glitch = 1'b1;
                end else if (run == RUN_LAST) begin
                    filt_nxt = 1'b0;
                    fall_nxt = 1'b1;
                end
            end
            default: begin
                filt_nxt = filt_out;
            end
        endcase
    end

`ifdef MUX_FILT_GLITCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturating glitch counter; a glitch in the clear cycle still counts as the first one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (glitch) begin
            if (glitch_clr) begin
                glitch_cnt <= CNT_ONE;
            end else if (glitch_cnt != CNT_MAX) begin
                glitch_cnt <= glitch_cnt + CNT_ONE;
            end
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end
    end
`else
    logic unused_cnt_inputs;

    // No counter in this build; the clear input and glitch flag go nowhere
    assign unused_cnt_inputs = &{1'b0, glitch_clr, glitch};
    assign glitch_cnt        = '0;
`endif

endmodule

// File: tb/tb_mux_out_filter.sv
// tb/tb_mux_out_filter.sv - scoreboard bench for mux_out_filter
module tb_mux_out_filter;

    localparam int SC = 4;
`ifdef MUX_FILT_GLITCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       z_in;
    logic       glitch_clr;
    logic       filt_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] glitch_cnt;
    logic       filt_s;
    logic       rise_s;
    logic       fall_s;
    logic [1:0] cnt_s;

    mux_out_filter #(.STABLE_CYCLES(SC), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .z_in       (z_in),
        .glitch_clr (glitch_clr),
        .filt_out   (filt_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .glitch_cnt (glitch_cnt)
    );

    mux_out_filter #(.STABLE_CYCLES(SC), .CNT_W(2)) u_dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .z_in       (z_in),
        .glitch_clr (glitch_clr),
        .filt_out   (filt_s),
        .rise_pulse (rise_s),
        .fall_pulse (fall_s),
        .glitch_cnt (cnt_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit rise;
        int t;
    } ev_t;

    ev_t sb[$];
    bit  acc     = 1'b0;
    int  exp_cnt = 0;
    int  exp_sat = 0;

    task automatic model_glitch();
        if (CNT_EN) begin
            if (exp_cnt < 255) exp_cnt++;
            if (exp_sat < 3) exp_sat++;
        end
    endtask

    // Hold z_in at v for len samples; pushes the expected strobe or counts a glitch
    task automatic drive_seg(input bit v, input int len);
        ev_t e;
        z_in = v;
        if (v != acc) begin
            if (len >= SC) begin
                e.rise = v;
                e.t    = cyc + 2 + SC;
                sb.push_back(e);
                acc = v;
            end else begin
                model_glitch();
            end
        end
        repeat (len) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_filt"}, filt_out, acc);
        check({tag, "_cnt"}, glitch_cnt, exp_cnt);
        check({tag, "_sat_filt"}, filt_s, acc);
        check({tag, "_sat_cnt"}, cnt_s, exp_sat);
    endtask

    ev_t got;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (rise_pulse || fall_pulse)) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {rise_pulse, fall_pulse}, 0);
            end else begin
                got = sb.pop_front();
                check("strobe_rise", rise_pulse, got.rise);
                check("strobe_fall", fall_pulse, !got.rise);
                check("strobe_cycle", cyc, got.t);
                check("strobe_level", filt_out, got.rise);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        z_in       = 1'b0;
        glitch_clr = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            z_in = i[0];
            check("rst_out", {filt_out, rise_pulse, fall_pulse}, 0);
            check("rst_cnt", glitch_cnt, 0);
        end

        @(negedge clk);
        z_in  = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_out", {filt_out, rise_pulse, fall_pulse}, 0);
        end

        drive_seg(1'b1, 8);
        check_state("clean_rise");
        drive_seg(1'b0, 8);
        check_state("clean_fall");

        drive_seg(1'b1, 3);
        drive_seg(1'b0, 8);
        check_state("short_hi");
        drive_seg(1'b1, 4);
        drive_seg(1'b1, 4);
        check_state("exact_hi");
        drive_seg(1'b0, 3);
        drive_seg(1'b1, 6);
        check_state("short_lo");
        drive_seg(1'b0, 4);
        drive_seg(1'b0, 4);
        check_state("exact_lo");

        for (int i = 0; i < 6; i++) begin
            drive_seg(1'b1, 1);
            drive_seg(1'b0, 1);
        end
        drive_seg(1'b0, 8);
        check_state("toggle");

        glitch_clr = 1'b1;
        @(negedge clk);
        glitch_clr = 1'b0;
        exp_cnt    = 0;
        exp_sat    = 0;
        check_state("clear");

        drive_seg(1'b1, 2);
        drive_seg(1'b0, 2);
        glitch_clr = 1'b1;
        @(negedge clk);
        glitch_clr = 1'b0;
        exp_cnt    = CNT_EN ? 1 : 0;
        exp_sat    = CNT_EN ? 1 : 0;
        drive_seg(1'b0, 6);
        check_state("clear_and_glitch");

        z_in = 1'b1;
        repeat (5) @(negedge clk);
        rst_n   = 1'b0;
        z_in    = 1'b0;
        acc     = 1'b0;
        exp_cnt = 0;
        exp_sat = 0;
        repeat (3) @(negedge clk);
        check("pend_rst_out", {filt_out, rise_pulse, fall_pulse}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_state("pend_rst");

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_seg(1'b1, 8);
        check_state("release_hi");
        drive_seg(1'b0, 8);
        check_state("release_back");

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
